// File: rtl/result_stream_buffer.sv
// rtl/result_stream_buffer.sv - captures one addressed result frame, then streams it as packed 2-element beats
module result_stream_buffer #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [DW-1:0]   i_wr_data,
  input  logic            i_fill_done,
  output logic [2*DW-1:0] o_tdata,
  output logic            o_tvalid,
  input  logic            i_tready,
  output logic            o_tlast,
  output logic            o_busy,
  output logic            o_frame_done,
  output logic            o_wr_err
);

  localparam int HALF = DEPTH / 2;
  localparam int BAW  = AW - 1;

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic            fill_done_q;
  logic            start_q;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            rd_en;
  logic [BAW-1:0]  rd_addr;
  logic            hold_vld_q, hold_last_q;
  logic [DW-1:0]   hold_even_q, hold_odd_q;
  logic            hs, out_load, rise, wr_ok;

  logic [DW-1:0]   bank_even [HALF];
  logic [DW-1:0]   bank_odd  [HALF];

  assign hs       = o_tvalid && i_tready;
  assign out_load = hold_vld_q && (!o_tvalid || hs);
  assign rise     = i_fill_done && !fill_done_q;
  assign wr_ok    = i_wr_en && (state_q == S_FILL);
  assign o_busy   = (state_q == S_DRAIN);

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_en    = 1'b0;
    rd_addr  = rd_ptr_q[BAW-1:0];
    case (state_q)
      S_FILL: begin
        if (start_q) begin
          state_d  = S_DRAIN;
          rd_en    = 1'b1;
          rd_addr  = '0;
          rd_ptr_d = AW'(1);
        end
      end
      S_DRAIN: begin
        // The RAM output register doubles as the hold stage: it is only
        // re-read once its current beat has moved into the output register.
        if (rd_ptr_q < AW'(HALF) && (!hold_vld_q || out_load)) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (hs && o_tlast) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_FILL;
      fill_done_q  <= 1'b0;
      start_q      <= 1'b0;
      rd_ptr_q     <= '0;
      hold_vld_q   <= 1'b0;
      hold_last_q  <= 1'b0;
      o_tvalid     <= 1'b0;
      o_tdata      <= '0;
      o_tlast      <= 1'b0;
      o_frame_done <= 1'b0;
      o_wr_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_done_q  <= i_fill_done;
      start_q      <= rise && (state_q == S_FILL);
      rd_ptr_q     <= rd_ptr_d;
      o_frame_done <= hs && o_tlast;
      if (i_wr_en && state_q == S_DRAIN) o_wr_err <= 1'b1;

      if (rd_en) begin
        hold_vld_q  <= 1'b1;
        hold_last_q <= (rd_addr == BAW'(HALF - 1));
      end else if (out_load) begin
        hold_vld_q  <= 1'b0;
      end

      if (out_load) begin
        o_tvalid <= 1'b1;
        o_tdata  <= {hold_odd_q, hold_even_q};
        o_tlast  <= hold_last_q;
      end else if (hs) begin
        o_tvalid <= 1'b0;
        o_tlast  <= 1'b0;
      end
    end
  end

  // Frame storage is deliberately not reset; contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_wr_addr[0]) bank_even[i_wr_addr[AW-1:1]] <= i_wr_data;
    if (wr_ok &&  i_wr_addr[0]) bank_odd[i_wr_addr[AW-1:1]]  <= i_wr_data;
    if (rd_en) begin
      hold_even_q <= bank_even[rd_addr];
      hold_odd_q  <= bank_odd[rd_addr];
    end
  end

endmodule

// File: tb/tb_result_stream_buffer.sv
// tb/tb_result_stream_buffer.sv - directed self-checking bench for result_stream_buffer
module tb_result_stream_buffer;

  logic        i_clk, i_rst;
  logic        i_wr_en;
  logic [9:0]  i_wr_addr;
  logic [15:0] i_wr_data;
  logic        i_fill_done;
  logic [31:0] o_tdata;
  logic        o_tvalid, i_tready, o_tlast, o_busy, o_frame_done, o_wr_err;

  result_stream_buffer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_fill_done(i_fill_done), .o_tdata(o_tdata),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tlast(o_tlast), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_wr_err(o_wr_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] mem   [1024];
  logic [31:0] beats [1024];
  logic        lasts [1024];
  int          nbeats, fd_c, fd_cnt, stall_bad;
  logic        busy0, busy1, tv1, tv2, busy_fd, tv_fd, aborted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    i_wr_en   = 1'b1;
    i_wr_addr = a[9:0];
    i_wr_data = d;
    mem[a]    = d;
    @(negedge i_clk);
  endtask

  function automatic int seq_bad();
    int bad = 0;
    for (int k = 0; k < 512; k++) begin
      if (beats[k] !== {mem[2*k+1], mem[2*k]}) bad++;
      if (lasts[k] !== (k == 511)) bad++;
    end
    return bad;
  endfunction

  // c counts negedges after edge N (the edge that samples the fill_done rise)
  task automatic run_drain(input bit rnd, input int err_c, input int abort_n);
    logic        prev_stall = 1'b0;
    logic [31:0] pdata = '0;
    logic        plast = 1'b0;
    nbeats = 0; fd_c = -1; fd_cnt = 0; stall_bad = 0; aborted = 1'b0;
    busy_fd = 1'b1; tv_fd = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk);
      i_wr_en = 1'b0;
      if (abort_n >= 0 && nbeats == abort_n + 1) begin
        aborted = 1'b1;
        i_rst = 1'b1;
        #1;
        break;
      end
      if (c == 0) busy0 = o_busy;
      if (c == 1) begin busy1 = o_busy; tv1 = o_tvalid; end
      if (c == 2) tv2 = o_tvalid;
      if (prev_stall && (!o_tvalid || o_tdata !== pdata || o_tlast !== plast)) stall_bad++;
      if (o_frame_done) begin
        fd_cnt++;
        if (fd_c < 0) begin fd_c = c; busy_fd = o_busy; tv_fd = o_tvalid; end
      end
      if (fd_c >= 0 && c == fd_c + 2) break;
      if (c == err_c) begin
        i_wr_en = 1'b1; i_wr_addr = 10'd5; i_wr_data = 16'h1234;
      end
      i_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_tvalid && i_tready && nbeats < 1024) begin
        beats[nbeats] = o_tdata;
        lasts[nbeats] = o_tlast;
        nbeats++;
      end
      prev_stall = o_tvalid && !i_tready;
      pdata = o_tdata;
      plast = o_tlast;
    end
  endtask

  initial begin
    logic [15:0] v;
    i_rst = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_fill_done = 1'b0; i_tready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", {o_tvalid, o_tlast, o_busy, o_frame_done, o_wr_err, o_tdata}, 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Ramp frame, continuous ready
    for (int i = 0; i < 1024; i++) wr(i, 16'(i));
    i_wr_en = 1'b0;
    i_fill_done = 1'b1;
    run_drain(1'b0, -1, -1);
    chk("ramp_busy_edgeN", busy0, 1'b0);
    chk("ramp_busy_edgeN1", busy1, 1'b1);
    chk("ramp_tvalid_edgeN1", tv1, 1'b0);
    chk("ramp_tvalid_edgeN2", tv2, 1'b1);
    chk("ramp_nbeats", nbeats, 512);
    chk("ramp_beat0", beats[0], 32'h0001_0000);
    chk("ramp_beat1", beats[1], 32'h0003_0002);
    chk("ramp_beat511", beats[511], 32'h03FF_03FE);
    chk("ramp_last511", lasts[511], 1'b1);
    chk("ramp_seq_errors", seq_bad(), 0);
    // sampled just before edge N+515, i.e. high after edge N+514
    chk("ramp_frame_done_cycle", fd_c, 514);
    chk("ramp_frame_done_width", fd_cnt, 1);
    chk("ramp_busy_at_done", busy_fd, 1'b0);
    chk("ramp_tvalid_at_done", tv_fd, 1'b0);

    // Same frame again under random backpressure
    i_fill_done = 1'b0;
    @(negedge i_clk);
    i_fill_done = 1'b1;
    run_drain(1'b1, -1, -1);
    chk("bp_nbeats", nbeats, 512);
    chk("bp_seq_errors", seq_bad(), 0);
    chk("bp_stall_unstable", stall_bad, 0);
    chk("bp_frame_done_width", fd_cnt, 1);

    // Write during drain is dropped and flags the sticky error
    chk("wr_err_before", o_wr_err, 1'b0);
    i_fill_done = 1'b0;
    @(negedge i_clk);
    i_fill_done = 1'b1;
    run_drain(1'b0, 3, -1);
    chk("wr_err_beat2_old", beats[2], 32'h0005_0004);
    chk("wr_err_seq_errors", seq_bad(), 0);
    chk("wr_err_set", o_wr_err, 1'b1);
    repeat (5) @(negedge i_clk);
    chk("wr_err_sticky", o_wr_err, 1'b1);

    // Asynchronous reset after beat-100 handshake
    i_fill_done = 1'b0;
    @(negedge i_clk);
    i_fill_done = 1'b1;
    run_drain(1'b0, -1, 100);
    chk("rst_aborted", aborted, 1'b1);
    chk("rst_outputs_async", {o_tvalid, o_tlast, o_busy, o_frame_done, o_wr_err, o_tdata}, 64'd0);
    i_fill_done = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_idle_after_release", {o_tvalid, o_busy, o_wr_err}, 3'd0);
    i_fill_done = 1'b1;
    run_drain(1'b0, -1, -1);
    chk("rst_retained_beat0", beats[0], 32'h0001_0000);
    chk("rst_retained_seq", seq_bad(), 0);

    // Back-to-back frame with inverted ramp
    i_fill_done = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      v = 16'(i);
      wr(i, ~v);
    end
    i_wr_en = 1'b0;
    i_fill_done = 1'b1;
    run_drain(1'b0, -1, -1);
    chk("inv_beat0", beats[0], 32'hFFFE_FFFF);
    chk("inv_seq_errors", seq_bad(), 0);

    // Signed values plus write coincident with the fill edge
    i_fill_done = 1'b0;
    wr(0, 16'h8000);
    wr(1, 16'hFFFF);
    i_wr_en = 1'b1; i_wr_addr = 10'd1023; i_wr_data = 16'hABCD; mem[1023] = 16'hABCD;
    i_fill_done = 1'b1;
    run_drain(1'b0, -1, -1);
    chk("signed_beat0", beats[0], 32'hFFFF_8000);
    chk("signed_beat1", beats[1], 32'hFFFC_FFFD);
    chk("edge_write_beat511", beats[511], 32'hABCD_FC01);
    chk("signed_seq_errors", seq_bad(), 0);
    chk("signed_no_wr_err", o_wr_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/result_stream_buffer.md
# result_stream_buffer

Result frame buffer that sits directly downstream of the systolic array's output flattener. It captures one 32x32 frame of 16-bit results, delivered as addressed single-element writes, into on-chip RAM. Once the flattener signals completion, it streams the frame out as 512 packed 32-bit beats over a valid/ready interface toward the DMA/host path, then re-arms for the next frame.

## Interface
- DEPTH, 1024: elements per frame (32x32); must be even.
- AW, 10: element address width, log2(DEPTH).
- DW, 16: element width in bits.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wr_en  in  1  element write strobe from the flattener.
- i_wr_addr  in  AW  element index (row*32+col).
- i_wr_data  in  DW  element value (signed, stored bit-exact).
- i_fill_done  in  1  flattener done level; its rising edge ends the fill.
- o_tdata  out  2*DW  packed beat {elem[2k+1], elem[2k]}.
- o_tvalid  out  1  beat valid.
- i_tready  in  1  consumer ready.
- o_tlast  out  1  high on the final beat (k = DEPTH/2-1).
- o_busy  out  1  high while in DRAIN.
- o_frame_done  out  1  one-cycle pulse after the last beat handshake.
- o_wr_err  out  1  sticky; a write arrived during DRAIN.

## Operation
- Storage: two banks of DEPTH/2 x DW with synchronous read. i_wr_addr[0] selects the bank (0 = even, 1 = odd). i_wr_addr[AW-1:1] is the bank address. Both banks are read with the same address, so one beat is produced per read.
- FSM with states FILL (reset state) and DRAIN.
- FILL:
  - Every i_wr_en write is stored.
  - Duplicate addresses: the last write wins.
  - Unwritten locations hold stale contents. There is no error for this.
- Rising-edge detect: fill_done_q <= i_fill_done; fill_done_q resets to 0. A level already high at reset release counts as an edge.
- FILL -> DRAIN on a rising edge of i_fill_done.
  - A write in the same cycle as the edge is stored.
  - Beat counter k is cleared to 0.
- DRAIN:
  - Emit beats k = 0 .. DEPTH/2-1 in order.
  - k advances only on a handshake (o_tvalid && i_tready).
  - Edges on i_fill_done are ignored.
  - Writes are dropped and set o_wr_err.
- DRAIN -> FILL on the handshake of beat DEPTH/2-1. o_frame_done pulses in the following cycle.
- o_wr_err stays high until i_rst. No other event clears it.
- RAM contents are not cleared by reset.

## Timing
- Reset values: o_tvalid 0, o_tlast 0, o_tdata 0, o_busy 0, o_frame_done 0, o_wr_err 0. Counter k = 0, state FILL.
- Write latency: a write sampled at edge E is readable by any read issued at edge E+1 or later.
- Edge N samples the i_fill_done rising edge:
  - o_busy = 1 from after edge N+1.
  - o_tvalid = 1 from after edge N+2 (read pipeline fill), with beat 0 on o_tdata.
- Throughput: 1 beat per cycle while i_tready is held high. With continuous ready, the last handshake is at edge N+2+DEPTH/2. o_frame_done is high for one cycle after that edge, and o_busy and o_tvalid are 0 at that point.
- AXI-stream rules:
  - Once asserted, o_tvalid stays high until the handshake.
  - o_tdata and o_tlast are stable while o_tvalid && !i_tready.
  - o_tvalid does not depend combinationally on i_tready.
  - A skid/hold register is required to absorb the 1-cycle RAM latency under backpressure.
- A handshake on any cycle, including the first o_tvalid cycle and after any stall length, is accepted with no bubble lost.
- Asynchronous reset mid-DRAIN:
  - All outputs go to reset values immediately and the state returns to FILL.
  - The next i_fill_done rising edge starts a new drain from beat 0.

## Test plan
- Ramp frame, i_tready=1: write data = address for 0..1023, then raise i_fill_done. Expect:
  - beat 0 = 0x0001_0000, beat 1 = 0x0003_0002, beat 511 = 0x03FF_03FE with o_tlast=1;
  - exactly 512 beats;
  - o_frame_done pulse at edge N+515;
  - o_busy low afterwards.
- Random i_tready backpressure (~50% duty): o_tdata and o_tlast held stable during stalls. Sequence identical to the ramp case. No beat lost or duplicated.
- Write with i_wr_addr=5, data 0x1234 during DRAIN: o_wr_err rises and stays 1. Streamed beat 2 still equals 0x0005_0004 (old data). o_wr_err clears only on i_rst.
- Assert i_rst after the beat-100 handshake: all outputs 0. Re-raise i_fill_done with no new writes: beat 0 = 0x0001_0000 again (RAM retained).
- Back-to-back frames: after o_frame_done, drop i_fill_done, write frame 2 with the inverted ramp, raise i_fill_done. Frame 2 beat 0 = 0xFFFE_FFFF.
- Signed values: elements 0x8000 at index 0 and 0xFFFF at index 1 yield beat 0 = 0xFFFF_8000. The same-cycle write plus fill edge at index 1023 is stored.
